// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state, line and CRC definitions
// for the USB transmit packetizer.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      CRC,
      EOP_SE0,
      EOP_J
   } tx_state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   localparam logic [2:0] STUFF_LIMIT = 3'd6;

   // Byte folded in LSB first, matching wire order.
   function automatic logic [15:0] crc16_byte(
      input logic [15:0] c,
      input logic [7:0]  d
   );
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC16_POLY;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: synchronous byte FIFO carrying a
// per-byte last flag, with occupancy output.
module usb_tx_fifo
   import usb_tx_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  fifo_entry_t                  wr_data,
   input  logic                         rd_en,
   output fifo_entry_t                  rd_data,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   fifo_entry_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          empty;
   logic          do_wr;
   logic          do_rd;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_wr) - LW'(do_rd);
      end
   end

endmodule

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: buffered USB packet serializer (SYNC, stuffed NRZI
// data, EOP). Define USB_TX_CRC16_EN to append a CRC16 after the payload.
module usb_tx_packetizer
   import usb_tx_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 4,
   parameter int SYNC_BITS    = 8
) (
   input  logic                              clk,
   input  logic                              RST,
   input  logic [7:0]                        tx_data,
   input  logic                              tx_valid,
   input  logic                              tx_last,
   output logic                              tx_ready,
   output logic                              d_plus_out,
   output logic                              d_minus_out,
   output logic                              tx_oe,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              tx_done
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CPB_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [5:0]    SYNC_LAST = 6'(SYNC_BITS - 1);

   tx_state_t     state, state_n;
   logic [CW-1:0] tick_cnt, tick_n;
   logic [5:0]    bit_idx, bit_n;
   logic [2:0]    ones, ones_n;
   logic [7:0]    shreg, shreg_n;
   logic          last_q, last_n;
   logic          line_j, line_n;
   logic          se0, se0_n;
   logic          done_n;
   logic [LW-1:0] pkt_count;
`ifdef USB_TX_CRC16_EN
   logic [15:0]   crc, crc_n;
`endif

   logic          tick;
   logic          send;
   logic          nb;
   logic          cnt_ones;
   logic          fifo_rd;
   logic          full;
   fifo_entry_t   rd;
   fifo_entry_t   wr_entry;

   assign tx_ready = !full;
   assign wr_entry = {tx_last, tx_data};
   assign tick     = (tick_cnt == CPB_LAST);
   assign tx_oe    = (state != IDLE);
   assign {d_plus_out, d_minus_out} =
      se0 ? LINE_SE0 : (line_j ? LINE_J : LINE_K);

   usb_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (RST),
      .wr_en   (tx_valid),
      .wr_data (wr_entry),
      .rd_en   (fifo_rd),
      .rd_data (rd),
      .full    (full),
      .level   (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         ones      <= '0;
         shreg     <= '0;
         last_q    <= 1'b0;
         line_j    <= 1'b1;
         se0       <= 1'b0;
         tx_done   <= 1'b0;
         pkt_count <= '0;
`ifdef USB_TX_CRC16_EN
         crc       <= CRC16_INIT;
`endif
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_n;
         bit_idx   <= bit_n;
         ones      <= ones_n;
         shreg     <= shreg_n;
         last_q    <= last_n;
         line_j    <= line_n;
         se0       <= se0_n;
         tx_done   <= done_n;
         pkt_count <= pkt_count
                    + LW'(tx_valid && !full && tx_last)
                    - LW'(fifo_rd && rd.last);
`ifdef USB_TX_CRC16_EN
         crc       <= crc_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      tick_n   = '0;
      bit_n    = bit_idx;
      ones_n   = ones;
      shreg_n  = shreg;
      last_n   = last_q;
      line_n   = line_j;
      se0_n    = se0;
      done_n   = 1'b0;
      fifo_rd  = 1'b0;
      send     = 1'b0;
      nb       = 1'b0;
      cnt_ones = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_n    = crc;
`endif
      if (state != IDLE) tick_n = tick ? '0 : tick_cnt + 1'b1;

      unique case (state)
         IDLE: if (pkt_count != '0) begin
            state_n = SYNC;
            bit_n   = '0;
            ones_n  = '0;
            send    = 1'b1;
`ifdef USB_TX_CRC16_EN
            crc_n   = CRC16_INIT;
`endif
         end
         SYNC: if (tick) begin
            send = 1'b1;
            if (bit_idx == SYNC_LAST) begin
               state_n  = DATA;
               bit_n    = '0;
               fifo_rd  = 1'b1;
               shreg_n  = rd.data;
               last_n   = rd.last;
               nb       = rd.data[0];
               cnt_ones = 1'b1;
            end else begin
               bit_n = bit_idx + 6'd1;
               nb    = (bit_idx + 6'd1 == SYNC_LAST);
            end
         end
         DATA: if (tick) begin
            send     = 1'b1;
            cnt_ones = 1'b1;
            if (ones == STUFF_LIMIT) begin
               nb = 1'b0;
            end else if (bit_idx != 6'd7) begin
               bit_n   = bit_idx + 6'd1;
               shreg_n = shreg >> 1;
               nb      = shreg[1];
            end else if (!last_q) begin
               fifo_rd = 1'b1;
               shreg_n = rd.data;
               last_n  = rd.last;
               nb      = rd.data[0];
               bit_n   = '0;
`ifdef USB_TX_CRC16_EN
               crc_n   = crc16_byte(crc, rd.data);
`endif
            end else begin
`ifdef USB_TX_CRC16_EN
               state_n = CRC;
               bit_n   = '0;
               nb      = ~crc[15];
`else
               send     = 1'b0;
               cnt_ones = 1'b0;
               state_n  = EOP_SE0;
               bit_n    = '0;
               se0_n    = 1'b1;
`endif
            end
         end
         CRC: begin
`ifdef USB_TX_CRC16_EN
            if (tick) begin
               send     = 1'b1;
               cnt_ones = 1'b1;
               if (ones == STUFF_LIMIT) begin
                  nb = 1'b0;
               end else if (bit_idx != 6'd15) begin
                  bit_n = bit_idx + 6'd1;
                  crc_n = {crc[14:0], 1'b0};
                  nb    = ~crc[14];
               end else begin
                  send     = 1'b0;
                  cnt_ones = 1'b0;
                  state_n  = EOP_SE0;
                  bit_n    = '0;
                  se0_n    = 1'b1;
               end
            end
`endif
         end
         EOP_SE0: if (tick) begin
            if (bit_idx == '0) begin
               bit_n = 6'd1;
            end else begin
               state_n = EOP_J;
               se0_n   = 1'b0;
               line_n  = 1'b1;
            end
         end
         EOP_J: if (tick) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase

      // NRZI: a zero toggles the line, a one holds it.
      if (send) begin
         line_n = nb ? line_j : ~line_j;
         if (cnt_ones) ones_n = nb ? ones + 3'd1 : '0;
      end
   end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: scoreboard bench; each queued packet is
// expanded by a bit-level model into expected line symbols.
`timescale 1ns/1ps
module tb_usb_tx_packetizer;

   localparam int FD  = 16;
   localparam int CPB = 4;
   localparam int SB  = 8;
   localparam int LW  = $clog2(FD + 1);
   localparam logic [1:0] SJ = 2'b10;
   localparam logic [1:0] SK = 2'b01;
   localparam logic [1:0] SS = 2'b00;

   logic          clk = 1'b0;
   logic          RST = 1'b1;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_valid = 1'b0;
   logic          tx_last = 1'b0;
   logic          tx_ready;
   logic          d_plus_out;
   logic          d_minus_out;
   logic          tx_oe;
   logic [LW-1:0] fifo_level;
   logic          tx_done;

   int total = 0;
   int bad = 0;
   logic [1:0] sym_q[$];
   int         len_q[$];
   logic [7:0] pkt[$];
   int exp_done = 0;
   int done_seen = 0;
   bit mon_skip = 1'b1;
   bit in_pkt = 1'b0;
   int clk_cnt = 0;
   int exp_len = 0;
   int popped = 0;
   logic [1:0] cur_sym = 2'b11;

   always #5 clk = ~clk;

   usb_tx_packetizer #(
      .FIFO_DEPTH   (FD),
      .CLKS_PER_BIT (CPB),
      .SYNC_BITS    (SB)
   ) dut (
      .clk         (clk),
      .RST         (RST),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_last     (tx_last),
      .tx_ready    (tx_ready),
      .d_plus_out  (d_plus_out),
      .d_minus_out (d_minus_out),
      .tx_oe       (tx_oe),
      .fifo_level  (fifo_level),
      .tx_done     (tx_done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic push_pkt();
      logic b[$];
      logic v;
      logic fb;
      logic ln;
      int ones;
      logic [15:0] crc;
      ones = 0;
      crc = 16'hFFFF;
      for (int i = 0; i < SB; i++) b.push_back(i == SB - 1);
      foreach (pkt[i]) begin
         for (int j = 0; j < 8; j++) begin
            v = pkt[i][j];
            b.push_back(v);
            ones = v ? ones + 1 : 0;
            if (ones == 6) begin b.push_back(1'b0); ones = 0; end
            if (i > 0) begin
               fb = crc[15] ^ v;
               crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
         end
      end
`ifdef USB_TX_CRC16_EN
      for (int j = 15; j >= 0; j--) begin
         v = ~crc[j];
         b.push_back(v);
         ones = v ? ones + 1 : 0;
         if (ones == 6) begin b.push_back(1'b0); ones = 0; end
      end
`endif
      ln = 1'b1;
      foreach (b[k]) begin
         if (!b[k]) ln = ~ln;
         sym_q.push_back(ln ? SJ : SK);
      end
      sym_q.push_back(SS);
      sym_q.push_back(SS);
      sym_q.push_back(SJ);
      len_q.push_back(b.size() + 3);
      exp_done++;
   endtask

   task automatic wr(input logic [7:0] b, input logic l);
      tx_data = b;
      tx_valid = 1'b1;
      tx_last = l;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tx_last = 1'b0;
   endtask

   task automatic send_pkt();
      push_pkt();
      foreach (pkt[i]) wr(pkt[i], i == pkt.size() - 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((len_q.size() != 0 || in_pkt || tx_oe) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("timeout", n < 3000, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: per-clock line check against the expected symbol stream.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_skip) begin
            in_pkt = 0;
         end else begin
            if (tx_done) done_seen++;
            if (tx_oe) begin
               if (!in_pkt) begin
                  in_pkt = 1;
                  clk_cnt = 0;
                  popped = 0;
                  if (len_q.size() == 0) begin
                     check("unexpected_tx", tx_oe, 0);
                     exp_len = 0;
                  end else begin
                     exp_len = len_q.pop_front();
                  end
               end
               if (clk_cnt % CPB == 0) begin
                  cur_sym = 2'b11;
                  if (sym_q.size() != 0 && popped < exp_len) begin
                     cur_sym = sym_q.pop_front();
                     popped++;
                  end
               end
               check("line", {d_plus_out, d_minus_out}, cur_sym);
               clk_cnt++;
            end else if (in_pkt) begin
               in_pkt = 0;
               check("pkt_clks", clk_cnt, exp_len * CPB);
               check("done_pulse", tx_done, 1);
               while (popped < exp_len && sym_q.size() != 0) begin
                  void'(sym_q.pop_front());
                  popped++;
               end
            end else begin
               check("idle_line", {d_plus_out, d_minus_out}, SJ);
               check("idle_done", tx_done, 0);
            end
         end
      end
   end

   initial begin
      int hits;
      int d0;
      int n;
      RST = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", tx_ready, 1);
      check("rst_level", fifo_level, 0);
      check("rst_dp", d_plus_out, 1);
      check("rst_dm", d_minus_out, 0);
      check("rst_oe", tx_oe, 0);
      check("rst_done", tx_done, 0);
      @(posedge clk); #1;
      RST = 1'b0;
      mon_skip = 1'b0;

      pkt.delete(); pkt.push_back(8'hA5);
      send_pkt(); wait_idle();
      pkt.delete(); pkt.push_back(8'hFF); pkt.push_back(8'hFF);
      send_pkt(); wait_idle();
      pkt.delete(); pkt.push_back(8'hC3);
      send_pkt(); wait_idle();
      pkt.delete(); pkt.push_back(8'h00); pkt.push_back(8'hFC);
      send_pkt(); wait_idle();

      d0 = done_seen;
      pkt.delete();
      pkt.push_back(8'h69); pkt.push_back(8'h12); pkt.push_back(8'h34);
      send_pkt();
      pkt.delete(); pkt.push_back(8'hE1); pkt.push_back(8'h00);
      send_pkt();
      wait_idle();
      check("two_done", done_seen - d0, 2);

      repeat (4) begin
         pkt.delete();
         n = $urandom_range(1, 5);
         repeat (n) pkt.push_back(8'($urandom));
         send_pkt();
         wait_idle();
      end

      for (int i = 0; i <= FD; i++) begin
         check("ovf_ready", tx_ready, i < FD);
         wr(8'(i), 1'b0);
      end
      @(negedge clk);
      check("ovf_level", fifo_level, FD);
      check("ovf_full", tx_ready, 0);
      repeat (40) @(negedge clk);
      check("ovf_no_tx", tx_oe, 0);
      @(posedge clk); #1;
      RST = 1'b1;
      @(posedge clk); #1;
      RST = 1'b0;
      @(negedge clk);
      check("flush_level", fifo_level, 0);
      check("flush_ready", tx_ready, 1);
      @(posedge clk); #1;

      mon_skip = 1'b1;
      d0 = done_seen;
      wr(8'hA5, 1'b0); wr(8'h11, 1'b0); wr(8'h22, 1'b1);
      repeat (SB * CPB + 12) @(posedge clk);
      #1;
      check("abort_busy", tx_oe, 1);
      RST = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_dp", d_plus_out, 1);
      check("abort_dm", d_minus_out, 0);
      check("abort_oe", tx_oe, 0);
      check("abort_level", fifo_level, 0);
      check("abort_done", tx_done, 0);
      @(posedge clk); #1;
      RST = 1'b0;
      hits = 0;
      repeat (80) begin
         @(negedge clk);
         if (tx_oe || tx_done) hits++;
      end
      check("abort_quiet", hits, 0);
      @(posedge clk); #1;
      mon_skip = 1'b0;

      pkt.delete(); pkt.push_back(8'h5A); pkt.push_back(8'h7E);
      send_pkt(); wait_idle();

      check("ndone", done_seen, exp_done);
      check("sym_left", sym_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
